// File: rtl/spike_event_logger_pkg.sv
// Shared definitions for the spike event logger: read-FSM state encoding and
// helpers that derive the event word geometry from the timestamp width.
// Optional build macro: SPIKE_LOG_VPEAK_EN (appends a v_mem peak byte to events).
`ifndef WIDTH
`define WIDTH 16
`endif

package spike_event_logger_pkg;

  localparam int DEF_TS_WIDTH = 16;
  localparam int DEF_DEPTH    = 8;

`ifdef SPIKE_LOG_VPEAK_EN
  localparam int PEAK_BYTES = 1;
`else
  localparam int PEAK_BYTES = 0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  // Bytes per event as streamed on rd_data
  function automatic int calc_nbytes(input int ts_width);
    return ts_width / 8 + PEAK_BYTES;
  endfunction

  // Event word width stored in the FIFO
  function automatic int calc_evt_w(input int ts_width);
    return 8 * calc_nbytes(ts_width);
  endfunction

  // Width of the occupancy count (must represent 0..DEPTH)
  function automatic int calc_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of the byte index inside an event (at least one bit)
  function automatic int calc_bidx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous event FIFO. The head is visible on dout combinationally; a push
// and a pop may complete in the same cycle even when the FIFO is full.
module spike_evt_fifo
  import spike_event_logger_pkg::*;
#(
  parameter int EVT_W = 16,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [EVT_W-1:0]           din,
  output logic [EVT_W-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the write lands in the slot being vacated, which is read before the edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage array, data only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps rising edges of the neuron spike output,
// queues them in a small FIFO and streams each event MSB-first over an
// 8-bit rd_data / rd_valid / rd_en handshake.
// Optional build macro: SPIKE_LOG_VPEAK_EN -- events are committed when the
// spike falls and carry the top byte of the peak v_mem seen during the spike.
module spike_event_logger
  import spike_event_logger_pkg::*;
#(
  parameter int WIDTH    = `WIDTH,
  parameter int TS_WIDTH = DEF_TS_WIDTH,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic                        spike_in,
  input  logic signed [WIDTH-1:0]     v_mem,
  input  logic                        clear,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow
);

  localparam int NBYTES  = calc_nbytes(TS_WIDTH);
  localparam int EVT_W   = calc_evt_w(TS_WIDTH);
  localparam int BIDX_W  = calc_bidx_w(NBYTES);

  logic                rst_any;
  logic [TS_WIDTH-1:0] ts;
  logic                spike_prev;
  logic                spike_edge;
  logic                commit;
  logic [EVT_W-1:0]    commit_word;

  logic                fifo_push;
  logic                fifo_pop;
  logic [EVT_W-1:0]    fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;

  rd_state_t           state;
  rd_state_t           next_state;
  logic [BIDX_W-1:0]   bidx;
  logic                last_byte;
  logic                load;
  logic                shift;
  logic [EVT_W-1:0]    out_word;

  // Reset and clear have identical effect; clear also overrides all traffic
  assign rst_any    = reset | clear;
  assign spike_edge = valid_in & spike_in & ~spike_prev;

  // Timestamp counter and edge-detector history advance on valid samples only
  always_ff @(posedge clk) begin
    if (rst_any) begin
      ts         <= '0;
      spike_prev <= 1'b0;
    end else if (valid_in) begin
      ts         <= ts + TS_WIDTH'(1);
      spike_prev <= spike_in;
    end
  end

`ifdef SPIKE_LOG_VPEAK_EN
  logic signed [WIDTH-1:0] peak;
  logic signed [WIDTH-1:0] peak_now;
  logic [TS_WIDTH-1:0]     ts_hold;

  function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] peak_byte(input logic signed [WIDTH-1:0] p);
    return p[WIDTH-1 -: 8];
  endfunction

  // Running maximum including the current sample, so the falling cycle counts
  assign peak_now = smax(peak, v_mem);

  // Peak tracker: reload at the rising edge, accumulate while the spike is high
  always_ff @(posedge clk) begin
    if (spike_edge) begin
      peak    <= v_mem;
      ts_hold <= ts;
    end else if (valid_in & spike_prev) begin
      peak    <= peak_now;
    end
  end

  assign commit      = valid_in & spike_prev & ~spike_in;
  assign commit_word = {ts_hold, peak_byte(peak_now)};
`else
  logic unused_vmem;

  assign unused_vmem = ^v_mem;
  assign commit      = spike_edge;
  assign commit_word = ts;
`endif

  // A commit into a full FIFO is lost unless the reader frees a slot this cycle
  assign fifo_push = commit & ~rst_any;

  spike_evt_fifo #(
    .EVT_W (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (rst_any),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (commit_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign empty = fifo_empty;

  // Sticky drop indicator
  always_ff @(posedge clk) begin
    if (rst_any) begin
      overflow <= 1'b0;
    end else if (fifo_push & fifo_full & ~fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  assign last_byte = (bidx == BIDX_W'(NBYTES - 1));

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst_any) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Read FSM next-state: stay in SEND across back-to-back events
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = SEND;
      SEND:    if (rd_en && last_byte && fifo_empty) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read FSM outputs: handshake valid and FIFO pop / shifter controls
  always_comb begin
    rd_valid = (state == SEND);
    fifo_pop = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    if (!rst_any) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
          end
        end
        SEND: begin
          if (rd_en) begin
            if (last_byte) begin
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
                load     = 1'b1;
              end
            end else begin
              shift = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte index within the event being sent
  always_ff @(posedge clk) begin
    if (rst_any) begin
      bidx <= '0;
    end else if (load) begin
      bidx <= '0;
    end else if (shift) begin
      bidx <= bidx + BIDX_W'(1);
    end
  end

  // Output shift register: current byte always sits in the top 8 bits
  always_ff @(posedge clk) begin
    if (load) begin
      out_word <= fifo_dout;
    end else if (shift) begin
      out_word <= out_word << 8;
    end
  end

  assign rd_data = rd_valid ? out_word[EVT_W-1 -: 8] : 8'h00;

endmodule
